// File: rtl/vga_sync_if.sv
// VGA timing bundle: pixel strobe, raster coordinates, syncs and frame pulse.
// The generator drives every signal; consumers only observe and cannot stall it.
interface vga_sync_if;
  logic       p_tick;
  logic [9:0] x;
  logic [9:0] y;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic       frame_tick;

  modport master (output p_tick, x, y, hsync, vsync, video_on, frame_tick);
  modport slave  (input  p_tick, x, y, hsync, vsync, video_on, frame_tick);
endinterface

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: x/y/syncs update on the edge that ends each p_tick clk.
// Syncs are registered in step with x/y, video_on is combinational; free-running, no backpressure.
module vga_sync_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int PIX_DIV   = 4
) (
  input  logic       clk,
  input  logic       reset,
  vga_sync_if.master vga
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [9:0]       x_q;
  logic [9:0]       y_q;
  logic [9:0]       x_nxt;
  logic [9:0]       y_nxt;
  logic             hsync_q;
  logic             vsync_q;
  logic             tick;

  assign tick = (div_cnt == DIV_LAST);

  // Line and frame wrap resolve in one update, so (0,V_TOTAL) never appears.
  always_comb begin
    x_nxt = x_q;
    y_nxt = y_q;
    if (tick) begin
      if (x_q == H_LAST) begin
        x_nxt = 10'd0;
        y_nxt = (y_q == V_LAST) ? 10'd0 : y_q + 10'd1;
      end else begin
        x_nxt = x_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
      x_q     <= 10'd0;
      y_q     <= 10'd0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      x_q     <= x_nxt;
      y_q     <= y_nxt;
      hsync_q <= !((x_nxt >= HS_START) && (x_nxt <= HS_END));
      vsync_q <= !((y_nxt >= VS_START) && (y_nxt <= VS_END));
    end
  end

  assign vga.p_tick     = tick;
  assign vga.x          = x_q;
  assign vga.y          = y_q;
  assign vga.hsync      = hsync_q;
  assign vga.vsync      = vsync_q;
  assign vga.video_on   = (x_q < H_VIS) && (y_q < V_VIS);
  assign vga.frame_tick = tick && (x_q == H_LAST) && (y_q == V_LAST);

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: a shrunken-timing instance for whole-frame checks plus a default 640x480 instance for line checks.
module tb_vga_sync_gen;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  vga_sync_if s_if ();
  vga_sync_if d_if ();

  // Small timing: H_TOTAL 30 (hsync low x=20..25), V_TOTAL 19 (vsync low y=14..15).
  vga_sync_gen #(
    .H_DISPLAY(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(4),
    .V_DISPLAY(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
    .PIX_DIV(4)
  ) u_small (
    .clk   (clk),
    .reset (reset),
    .vga   (s_if)
  );

  vga_sync_gen u_dflt (
    .clk   (clk),
    .reset (reset),
    .vga   (d_if)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Default-instance line monitor
  int         cyc = 0;
  bit         mon_en = 1'b0;
  int         d_hs_fall_cyc = -1, d_hs_fall_x = -1;
  int         d_hs_rise_cyc = -1, d_hs_rise_x = -1;
  int         d_y1_cyc = -1, d_y1_x = -1;
  logic       d_hs_prev = 1'b1;
  logic [9:0] d_y_prev = 10'd0;

  task automatic sample();
    @(posedge clk);
    #1;
    cyc++;
    if (mon_en) begin
      if (d_hs_prev && !d_if.hsync && d_hs_fall_cyc < 0) begin
        d_hs_fall_cyc = cyc; d_hs_fall_x = int'(d_if.x);
      end
      if (!d_hs_prev && d_if.hsync && d_hs_rise_cyc < 0) begin
        d_hs_rise_cyc = cyc; d_hs_rise_x = int'(d_if.x);
      end
      if (d_y_prev == 10'd0 && d_if.y == 10'd1 && d_y1_cyc < 0) begin
        d_y1_cyc = cyc; d_y1_x = int'(d_if.x);
      end
      d_hs_prev = d_if.hsync;
      d_y_prev  = d_if.y;
    end
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_s_x"}, s_if.x, 0);
    chk({pfx, "_s_y"}, s_if.y, 0);
    chk({pfx, "_s_hsync"}, s_if.hsync, 1);
    chk({pfx, "_s_vsync"}, s_if.vsync, 1);
    chk({pfx, "_s_p_tick"}, s_if.p_tick, 0);
    chk({pfx, "_s_frame_tick"}, s_if.frame_tick, 0);
    chk({pfx, "_s_video_on"}, s_if.video_on, 1);
    chk({pfx, "_d_x"}, d_if.x, 0);
    chk({pfx, "_d_y"}, d_if.y, 0);
    chk({pfx, "_d_hsync"}, d_if.hsync, 1);
    chk({pfx, "_d_vsync"}, d_if.vsync, 1);
    chk({pfx, "_d_p_tick"}, d_if.p_tick, 0);
    chk({pfx, "_d_video_on"}, d_if.video_on, 1);
  endtask

  initial begin
    int found;
    int hs_lo, vs_lo, von, ft, ft_ok, x_max, y_max, c481, e481;
    int bad_hold, bad_ywrap, hs_fall_x, hs_rise_x, vs_fall_y, vs_rise_y;
    int von_x15, von_x16, von_y12, run;
    logic [9:0] px, py;
    logic phs, pvs, p481;

    // Reset held across several edges
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("rst");

    // Release; first pixel strobe and free-run for 20 clks
    @(negedge clk);
    reset  = 1'b1;
    cyc    = 0;
    mon_en = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      sample();
      chk($sformatf("run_ptick_%0d", i), s_if.p_tick, (i % 4 == 3) ? 1 : 0);
      chk($sformatf("run_x_%0d", i), s_if.x, i / 4);
      chk($sformatf("run_dx_%0d", i), d_if.x, i / 4);
    end

    // Align to the small instance's frame boundary
    found = 0;
    for (int i = 0; i < 5000 && found == 0; i++) begin
      sample();
      if (s_if.frame_tick) found = 1;
    end
    chk("frame_tick_seen", found, 1);
    chk("wrap_from_x", s_if.x, 29);
    chk("wrap_from_y", s_if.y, 18);
    sample();
    chk("frame_start_x", s_if.x, 0);
    chk("frame_start_y", s_if.y, 0);

    // One full small frame, 30*19*4 = 2280 clks
    hs_lo = 0; vs_lo = 0; von = 0; ft = 0; ft_ok = 0; x_max = 0; y_max = 0;
    c481 = 0; e481 = 0; bad_hold = 0; bad_ywrap = 0;
    hs_fall_x = -1; hs_rise_x = -1; vs_fall_y = -1; vs_rise_y = -1;
    von_x15 = 0; von_x16 = 0; von_y12 = 0; run = 0;
    px = s_if.x; py = s_if.y; phs = s_if.hsync; pvs = s_if.vsync; p481 = 1'b0;
    for (int i = 0; i < 2280; i++) begin
      if (i > 0) begin
        sample();
        if (s_if.x != px) begin
          if (run != 4) bad_hold++;
          run = 0;
        end
        if (s_if.y != py && px != 10'd29) bad_ywrap++;
        if (phs && !s_if.hsync && hs_fall_x < 0) hs_fall_x = int'(s_if.x);
        if (!phs && s_if.hsync && hs_rise_x < 0) hs_rise_x = int'(s_if.x);
        if (pvs && !s_if.vsync && vs_fall_y < 0) vs_fall_y = int'(s_if.y);
        if (!pvs && s_if.vsync && vs_rise_y < 0) vs_rise_y = int'(s_if.y);
      end
      run++;
      if (!s_if.hsync) hs_lo++;
      if (!s_if.vsync) vs_lo++;
      if (s_if.video_on) von++;
      if (s_if.video_on && s_if.x == 10'd15 && s_if.y == 10'd0) von_x15++;
      if (s_if.video_on && s_if.x == 10'd16 && s_if.y == 10'd0) von_x16++;
      if (s_if.video_on && s_if.x == 10'd0 && s_if.y == 10'd12) von_y12++;
      if (s_if.frame_tick) begin
        ft++;
        if (i == 2279 && s_if.x == 10'd29 && s_if.y == 10'd18) ft_ok++;
      end
      if (int'(s_if.x) > x_max) x_max = int'(s_if.x);
      if (int'(s_if.y) > y_max) y_max = int'(s_if.y);
      if (s_if.x == 10'd0 && s_if.y == 10'd13) begin
        c481++;
        if (!p481) e481++;
        p481 = 1'b1;
      end else begin
        p481 = 1'b0;
      end
      px = s_if.x; py = s_if.y; phs = s_if.hsync; pvs = s_if.vsync;
    end
    chk("hsync_low_clks", hs_lo, 456);
    chk("vsync_low_clks", vs_lo, 240);
    chk("video_on_clks", von, 768);
    chk("video_on_x15", von_x15, 4);
    chk("video_on_x16", von_x16, 0);
    chk("video_on_y12", von_y12, 0);
    chk("frame_tick_count", ft, 1);
    chk("frame_tick_pos", ft_ok, 1);
    chk("x_max", x_max, 29);
    chk("y_max", y_max, 18);
    chk("coord_0_13_clks", c481, 4);
    chk("coord_0_13_runs", e481, 1);
    chk("hold_violations", bad_hold, 0);
    chk("y_step_not_at_wrap", bad_ywrap, 0);
    chk("hsync_fall_x", hs_fall_x, 20);
    chk("hsync_rise_x", hs_rise_x, 26);
    chk("vsync_fall_y", vs_fall_y, 14);
    chk("vsync_rise_y", vs_rise_y, 16);
    sample();
    chk("frame_wrap_x", s_if.x, 0);
    chk("frame_wrap_y", s_if.y, 0);

    // Default-timing line measurements (3200 clks per line)
    chk("d_hsync_fall_x", d_hs_fall_x, 656);
    chk("d_hsync_fall_cyc", d_hs_fall_cyc, 2624);
    chk("d_hsync_rise_x", d_hs_rise_x, 752);
    chk("d_hsync_low_clks", d_hs_rise_cyc - d_hs_fall_cyc, 384);
    chk("d_line_clks", d_y1_cyc, 3200);
    chk("d_y_step_x", d_y1_x, 0);

    // Asynchronous reset mid-line inside both sync pulses
    found = 0;
    for (int i = 0; i < 3000 && found == 0; i++) begin
      sample();
      if (!s_if.hsync && !s_if.vsync) found = 1;
    end
    chk("both_sync_low_seen", found, 1);
    mon_en = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    chk_reset_vals("arst");

    @(negedge clk);
    reset = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      sample();
      chk($sformatf("rel_ptick_%0d", i), s_if.p_tick, (i == 3) ? 1 : 0);
      chk($sformatf("rel_x_%0d", i), s_if.x, (i == 4) ? 1 : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 Parameter H_DISPLAY, default 640, visible pixels per line.
REQ-002 Parameter H_FRONT, default 16, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, default 96, horizontal sync width in pixels.
REQ-004 Parameter H_BACK, default 48, horizontal back porch in pixels.
REQ-005 Parameter V_DISPLAY, default 480, visible lines per frame.
REQ-006 Parameter V_FRONT, default 10, vertical front porch in lines.
REQ-007 Parameter V_SYNC, default 2, vertical sync width in lines.
REQ-008 Parameter V_BACK, default 33, vertical back porch in lines.
REQ-009 Parameter PIX_DIV, default 4, clk cycles per pixel (100 MHz to 25 MHz).
REQ-010 clk  input  1  single system clock, 100 MHz; all state on its rising edge.
REQ-011 reset  input  1  asynchronous, active-low reset; asserted when 0.
REQ-012 p_tick  output  1  one-clk pulse marking each pixel period.
REQ-013 x  output  10  current horizontal count, 0..H_TOTAL-1.
REQ-014 y  output  10  current vertical count, 0..V_TOTAL-1.
REQ-015 hsync  output  1  horizontal sync, active-low.
REQ-016 vsync  output  1  vertical sync, active-low.
REQ-017 video_on  output  1  high while (x,y) is inside the visible area.
REQ-018 frame_tick  output  1  one-clk pulse when counters wrap to (0,0).

Function
REQ-019 H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK (525).
REQ-020 Divider counter SHALL count 0..PIX_DIV-1 and wrap; p_tick high for exactly the clk where divider = PIX_DIV-1, otherwise low.
REQ-021 x and y SHALL change only on the clk edge ending a p_tick cycle, and hold for PIX_DIV clks.
REQ-022 On p_tick: x < H_TOTAL-1 -> x+1; x = H_TOTAL-1 -> x = 0 and y advances.
REQ-023 y advance: y < V_TOTAL-1 -> y+1; y = V_TOTAL-1 -> y = 0.
REQ-024 x and y SHALL be driven straight from registers, never exceed H_TOTAL-1 / V_TOTAL-1, and use unsigned 10-bit arithmetic.
REQ-025 hsync and vsync SHALL be registers loaded from the next-state counters, so they align with x/y in the same clk.
REQ-026 hsync SHALL be 0 iff H_DISPLAY+H_FRONT <= x <= H_DISPLAY+H_FRONT+H_SYNC-1 (656..751).
REQ-027 vsync SHALL be 0 iff V_DISPLAY+V_FRONT <= y <= V_DISPLAY+V_FRONT+V_SYNC-1 (490..491).
REQ-028 video_on SHALL be combinational: (x < H_DISPLAY) and (y < V_DISPLAY).
REQ-029 frame_tick SHALL be high for exactly the one clk where p_tick = 1, x = H_TOTAL-1 and y = V_TOTAL-1.
REQ-030 Simultaneous line and frame wrap on the same p_tick SHALL produce (0,0) in a single update, with no intermediate (0,V_TOTAL).
REQ-031 Every (x,y) SHALL persist PIX_DIV clks, so a consumer decoding a single coordinate sees it PIX_DIV consecutive clks per frame.

Reset
REQ-032 While reset = 0: divider = 0, x = 0, y = 0, hsync = 1, vsync = 1, p_tick = 0, frame_tick = 0; video_on therefore = 1.
REQ-033 Reset assertion SHALL take effect immediately, regardless of clk, including mid-line or mid-sync.
REQ-034 After reset is released, the first p_tick SHALL occur on the PIX_DIV-th rising clk edge.

Verification
REQ-035 Reset pulse low mid-frame at x=700, y=300 -> all outputs at REQ-032 values within the same clk; first p_tick 4 clks after release.
REQ-036 Free-run 20 clks -> p_tick high every 4th clk, duty 1/4; x increments 0->5.
REQ-037 Run one line -> hsync falls with x=656, rises with x=752 (96 px = 384 clks); line length 3200 clks; y increments on the 799->0 wrap.
REQ-038 Run one frame -> vsync low only for y = 490 and 491 (1600 px); frame_tick exactly once per 420000 pixel ticks (1680000 clks), coincident with (799,524)->(0,0).
REQ-039 Sweep a frame -> video_on high for exactly 640x480 = 307200 pixel positions; low at x=640 and at y=480.
REQ-040 Monitor (x=0, y=481) -> held exactly 4 consecutive clks once per frame; x never reaches 800; y never reaches 525.
